// File: rtl/xnor_correlator_pkg.sv
// xcorr_pkg: shared types and constants for the xnor_correlator block.
//   xc_state_t : FSM state encoding (XC_FILL while the window fills, XC_RUN once full)
//   HC_W       : width of the optional hit counter
//   HC_MAX     : saturation value of the optional hit counter
package xcorr_pkg;

    typedef enum logic {
        XC_FILL = 1'b0,
        XC_RUN  = 1'b1
    } xc_state_t;

    localparam int HC_W = 16;
    localparam logic [HC_W-1:0] HC_MAX = {HC_W{1'b1}};

endpackage

// File: rtl/xnor_correlator_if.sv
// xcorr_if: serial input stream and registered result stream of the correlator.
// Ports:
//   in_valid, in_bit       : input bit, qualified by in_valid
//   out_valid, score, hit  : one-cycle result pulse with the window score
// Handshake: valid-only. A bit is taken on every rising edge where in_valid=1
// (and clear is low); there is no ready, the correlator always accepts.
// out_valid is a single-cycle pulse; score and hit are meaningful only with it,
// except that score holds its last value between pulses.
// Modports: master drives the input bits and observes results; slave is the correlator.
interface xcorr_if #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH + 1)
);
    logic          in_valid;
    logic          in_bit;
    logic          out_valid;
    logic [SW-1:0] score;
    logic          hit;

    modport master (
        output in_valid,
        output in_bit,
        input  out_valid,
        input  score,
        input  hit
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output out_valid,
        output score,
        output hit
    );
endinterface

// File: rtl/xnor_popcount.sv
// xnor_popcount: combinational match score of a window against a pattern.
// Ports:
//   win     : candidate window (already including the newest bit)
//   pattern : reference pattern
//   score   : number of bit positions where win equals pattern, 0..WIDTH
module xnor_popcount #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] win,
    input  logic [WIDTH-1:0] pattern,
    output logic [SW-1:0]    score
);

    logic [WIDTH-1:0] match;

    assign match = ~(win ^ pattern);

    // SW is wide enough for WIDTH, so the running sum never overflows.
    always_comb begin
        score = '0;
        for (int i = 0; i < WIDTH; i++) begin
            score = score + SW'(match[i]);
        end
    end

endmodule

// File: rtl/xnor_correlator.sv
// xnor_correlator: serial bit-stream correlator with a thresholded match score.
// Optional feature macro: XCORR_HIT_COUNT_EN adds the saturating hit_count port.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush of window and fill state (wins over in_valid)
//   pattern    : reference pattern, bit WIDTH-1 is the oldest position
//   threshold  : minimum score for a hit
//   bus        : xcorr_if slave (in_valid/in_bit in, out_valid/score/hit out)
//   hit_count  : saturating hit counter (XCORR_HIT_COUNT_EN only)
//   fsm_state  : current FSM state, for observation
module xnor_correlator
    import xcorr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] pattern,
    input  logic [SW-1:0]    threshold,
    xcorr_if.slave           bus,
`ifdef XCORR_HIT_COUNT_EN
    output logic [HC_W-1:0]  hit_count,
`endif
    output xc_state_t        fsm_state
);

    localparam int FW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] win_next;
    logic [FW-1:0]    fill_cnt;
    logic [FW-1:0]    fill_next;
    xc_state_t        state;
    xc_state_t        state_next;
    logic             emit;
    logic [SW-1:0]    score_next;
    logic             hit_next;

    // Newest bit enters at position 0, so MSB-first feeding lines up with pattern.
    assign win_next = {win[WIDTH-2:0], bus.in_bit};

    xnor_popcount #(.WIDTH(WIDTH), .SW(SW)) u_popcount (
        .win     (win_next),
        .pattern (pattern),
        .score   (score_next)
    );

    always_comb begin
        state_next = state;
        fill_next  = fill_cnt;
        emit       = 1'b0;
        if (clear) begin
            state_next = XC_FILL;
            fill_next  = '0;
        end else if (bus.in_valid) begin
            case (state)
                XC_FILL: begin
                    // The accept that completes the window already yields a result.
                    if (fill_cnt == FW'(WIDTH - 1)) begin
                        state_next = XC_RUN;
                        fill_next  = '0;
                        emit       = 1'b1;
                    end else begin
                        fill_next = fill_cnt + 1'b1;
                    end
                end
                XC_RUN: emit = 1'b1;
                default: state_next = XC_FILL;
            endcase
        end
    end

    assign hit_next  = emit && (score_next >= threshold);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= XC_FILL;
            fill_cnt      <= '0;
            win           <= '0;
            bus.out_valid <= 1'b0;
            bus.score     <= '0;
            bus.hit       <= 1'b0;
        end else begin
            state         <= state_next;
            fill_cnt      <= fill_next;
            bus.out_valid <= emit;
            bus.hit       <= hit_next;
            if (clear) begin
                win <= '0;
            end else if (bus.in_valid) begin
                win <= win_next;
            end
            // Score holds between results and during fill.
            if (emit) begin
                bus.score <= score_next;
            end
        end
    end

`ifdef XCORR_HIT_COUNT_EN
    // Counts at the same edge that raises the hit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (clear) begin
            hit_count <= '0;
        end else if (hit_next && (hit_count != HC_MAX)) begin
            hit_count <= hit_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_xnor_correlator.sv
// tb_xnor_correlator: directed self-checking bench for xnor_correlator (WIDTH=8).
module tb_xnor_correlator;
    import xcorr_pkg::*;

    localparam int WIDTH = 8;
    localparam int SW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [WIDTH-1:0] pattern;
    logic [SW-1:0]    threshold;
    xc_state_t        fsm_state;
`ifdef XCORR_HIT_COUNT_EN
    logic [HC_W-1:0]  hit_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    xcorr_if #(.WIDTH(WIDTH), .SW(SW)) bus ();

    xnor_correlator #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .pattern   (pattern),
        .threshold (threshold),
        .bus       (bus),
`ifdef XCORR_HIT_COUNT_EN
        .hit_count (hit_count),
`endif
        .fsm_state (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker: one immediate assertion per comparison.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drivers: outputs are sampled 1 time unit after the accepting edge.
    task automatic push(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    logic [7:0] vec;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        clear        = 1'b0;
        pattern      = 8'hA5;
        threshold    = 4'd8;
        rst_n        = 1'b0;
        repeat (3) idle();

        // Reset values
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(XC_FILL));
`ifdef XCORR_HIT_COUNT_EN
        chk("rst_hit_count", 32'(hit_count), 32'd0);
`endif
        rst_n = 1'b1;
        idle();

        // Reset mid-stream after 5 accepted bits
        for (int i = 0; i < 5; i++) push(1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_state", 32'(fsm_state), 32'(XC_FILL));
        chk("midrst_score", 32'(bus.score), 32'd0);
        idle();
        rst_n = 1'b1;
        idle();

        // Exact match: A5 MSB-first; nothing until the 8th bit after release
        vec = 8'hA5;
        for (int i = 7; i >= 1; i--) begin
            push(vec[i]);
            chk("fill_out_valid", 32'(bus.out_valid), 32'd0);
            chk("fill_score", 32'(bus.score), 32'd0);
        end
        push(vec[0]);
        chk("exact_out_valid", 32'(bus.out_valid), 32'd1);
        chk("exact_score", 32'(bus.score), 32'd8);
        chk("exact_hit", 32'(bus.hit), 32'd1);
        chk("exact_state", 32'(fsm_state), 32'(XC_RUN));

        // Partial: win=4B (01001011) vs A5 (10100101): xor=11101110 -> 2 matches
        push(1'b1);
        chk("part1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("part1_score", 32'(bus.score), 32'd2);
        chk("part1_hit", 32'(bus.hit), 32'd0);
        // win=96 (10010110) vs A5: xor=00110011 -> 4 matches, threshold 4 hits
        threshold = 4'd4;
        push(1'b0);
        chk("part2_score", 32'(bus.score), 32'd4);
        chk("part2_hit", 32'(bus.hit), 32'd1);

        // Idle: pulses drop, score holds
        idle();
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_hit", 32'(bus.hit), 32'd0);
        chk("idle_score", 32'(bus.score), 32'd4);

        // Gapped input after a clear: identical result to the exact match
        do_clear();
        chk("clr_state", 32'(fsm_state), 32'(XC_FILL));
        threshold = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            push(vec[i]);
            if (i != 0) begin
                chk("gap_fill_out_valid", 32'(bus.out_valid), 32'd0);
                idle();
                idle();
                chk("gap_idle_out_valid", 32'(bus.out_valid), 32'd0);
                chk("gap_idle_score", 32'(bus.score), 32'd4);
            end
        end
        chk("gap_out_valid", 32'(bus.out_valid), 32'd1);
        chk("gap_score", 32'(bus.score), 32'd8);
        chk("gap_hit", 32'(bus.hit), 32'd1);

        // Clear collides with a valid bit in RUN: no pulse, bit dropped
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        chk("coll_out_valid", 32'(bus.out_valid), 32'd0);
        chk("coll_hit", 32'(bus.hit), 32'd0);
        chk("coll_state", 32'(fsm_state), 32'(XC_FILL));
        // Feed 5A: complement of A5 -> 0 matches; threshold 0 still hits
        threshold = 4'd0;
        vec = 8'h5A;
        for (int i = 7; i >= 1; i--) begin
            push(vec[i]);
            chk("coll_fill_out_valid", 32'(bus.out_valid), 32'd0);
        end
        push(vec[0]);
        chk("thr0_out_valid", 32'(bus.out_valid), 32'd1);
        chk("thr0_score", 32'(bus.score), 32'd0);
        chk("thr0_hit", 32'(bus.hit), 32'd1);

        // threshold > WIDTH: win=B5 (10110101) vs A5 -> 7 matches, no hit
        threshold = 4'd9;
        push(1'b1);
        chk("thr9_score", 32'(bus.score), 32'd7);
        chk("thr9_hit", 32'(bus.hit), 32'd0);

        // Pattern change takes effect on the next bit: win=6B, pattern=6B
        pattern   = 8'h6B;
        threshold = 4'd8;
        push(1'b1);
        chk("newpat_score", 32'(bus.score), 32'd8);
        chk("newpat_hit", 32'(bus.hit), 32'd1);

`ifdef XCORR_HIT_COUNT_EN
        // Saturation: restart counting from zero, then 65540 hits with threshold 0
        do_clear();
        chk("hc_clr0", 32'(hit_count), 32'd0);
        threshold = 4'd0;
        for (int i = 0; i < 8; i++) push(1'b0);
        chk("hc_first", 32'(hit_count), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b0;
        repeat (65539) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("hc_sat", 32'(hit_count), 32'hFFFF);
        do_clear();
        chk("hc_clr", 32'(hit_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
